// File: rtl/pio_edge_event_master_pkg.sv
// Shared types and constants for the PIO edge-event master.
// Slave register map and service FSM encoding.
package pio_edge_event_master_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_PUSH
    } state_t;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam logic [31:0] PIO_CLEAR_ALL = 32'hFFFF_FFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pio_edge_event_master.sv
// Avalon-MM initiator servicing an edge-capture PIO slave and
// emitting timestamped edge events on a valid/ready stream.
module pio_edge_event_master
    import pio_edge_event_master_pkg::*;
#(
    parameter logic [31:0] IRQ_MASK = 32'hFFFF_FFFF,
    parameter logic [31:0] TS_INIT  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        irq,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [31:0] evt_bits,
    output logic [31:0] evt_time,
    output logic [15:0] spurious_cnt
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ts;
    logic [31:0] r_bits;
    logic [31:0] r_time;
    logic [15:0] r_spur;

    logic        w_cs;
    logic        w_wr_n;
    logic [1:0]  w_addr;
    logic [31:0] w_wdata;
    logic        w_valid;
    logic        w_capture;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cs      = 1'b0;
        w_wr_n    = 1'b1;
        w_addr    = PIO_ADDR_DATA;
        w_wdata   = 32'h0;
        w_valid   = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_cs    = 1'b1;
                w_wr_n  = 1'b0;
                w_addr  = PIO_ADDR_IRQMASK;
                w_wdata = IRQ_MASK;
                w_next  = ST_IDLE;
            end
            ST_IDLE: begin
                if (irq) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: begin
                w_cs   = 1'b1;
                w_addr = PIO_ADDR_EDGECAP;
                w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_cs      = 1'b1;
                w_wr_n    = 1'b0;
                w_addr    = PIO_ADDR_EDGECAP;
                w_wdata   = PIO_CLEAR_ALL;
                w_capture = 1'b1;
                w_next    = (|avm_readdata) ? ST_PUSH : ST_IDLE;
            end
            ST_PUSH: begin
                w_valid = 1'b1;
                if (evt_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_INIT;
            end
        endcase
    end

    // INIT is the reset state, so the bus is held quiet while reset is low.
    assign avm_chipselect = w_cs & reset_n;
    assign avm_write_n    = w_wr_n | ~reset_n;
    assign avm_address    = reset_n ? w_addr : PIO_ADDR_DATA;
    assign avm_writedata  = reset_n ? w_wdata : 32'h0;
    assign evt_valid      = w_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts <= TS_INIT;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bits <= 32'h0;
            r_time <= 32'h0;
            r_spur <= 16'h0;
        end else if (w_capture) begin
            r_bits <= avm_readdata;
            r_time <= r_ts;
            if (avm_readdata == 32'h0) begin
                r_spur <= sat_inc16(r_spur);
            end
        end
    end

    assign evt_bits     = r_bits;
    assign evt_time     = r_time;
    assign spurious_cnt = r_spur;

endmodule

// File: tb/tb_pio_edge_event_master.sv
// Bench for pio_edge_event_master with a behavioural edge-capture
// PIO slave and an event scoreboard.
module tb_pio_edge_event_master;

    localparam logic [31:0] TS0 = 32'hFFFF_FFFE;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        irq;
    logic        evt_valid;
    logic        evt_ready;
    logic [31:0] evt_bits;
    logic [31:0] evt_time;
    logic [15:0] spurious_cnt;

    logic [31:0] pins;
    logic        force_irq;

    logic [31:0] s_cap;
    logic [31:0] s_mask;
    logic [31:0] s_rd;
    logic [31:0] s_prev;
    int          s_mask_wr;
    logic [31:0] cyc;
    logic [15:0] exp_spur;

    typedef struct packed {
        logic [31:0] bits;
        logic [31:0] t;
    } ev_t;
    ev_t exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          nev = 0;
    logic        hold = 1'b0;
    logic [31:0] hb;
    logic [31:0] ht;

    always #5 clk = ~clk;

    pio_edge_event_master #(
        .IRQ_MASK(32'hFFFF_FFFF),
        .TS_INIT (TS0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .irq           (irq),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_bits      (evt_bits),
        .evt_time      (evt_time),
        .spurious_cnt  (spurious_cnt)
    );

    assign irq          = force_irq | (|(s_cap & s_mask));
    assign avm_readdata = s_rd;

    // Edge-capture PIO slave; its reads also feed the scoreboard.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_cap     <= 32'h0;
            s_mask    <= 32'h0;
            s_rd      <= 32'h0;
            s_prev    <= '1;
            s_mask_wr <= 0;
            cyc       <= 32'h0;
            exp_spur  <= 16'h0;
            exp_q.delete();
        end else begin
            cyc    <= cyc + 32'd1;
            s_prev <= pins;
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2) begin
                s_mask    <= avm_writedata;
                s_mask_wr <= s_mask_wr + 1;
            end
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
                s_cap <= s_prev & ~pins;
            else
                s_cap <= s_cap | (s_prev & ~pins);
            if (avm_chipselect && avm_write_n) begin
                if (avm_address == 2'd3) begin
                    s_rd <= s_cap;
                    if (s_cap == 32'h0) begin
                        if (exp_spur != 16'hFFFF)
                            exp_spur <= exp_spur + 16'd1;
                    end else begin
                        exp_q.push_back(ev_t'{bits: s_cap,
                                              t: TS0 + cyc + 32'd1});
                    end
                end else if (avm_address == 2'd2) begin
                    s_rd <= s_mask;
                end else begin
                    s_rd <= pins;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pre-edge monitoring uses the inputs as they stand for the next edge.
    task automatic tick();
        ev_t e;
        hold = evt_valid && !evt_ready;
        hb   = evt_bits;
        ht   = evt_time;
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", 32'(evt_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("evt_bits", evt_bits, e.bits);
                chk("evt_time", evt_time, e.t);
                nev++;
            end
        end
        @(negedge clk);
        if (hold) begin
            chk("hold_valid", 32'(evt_valid), 32'd1);
            chk("hold_bits", evt_bits, hb);
            chk("hold_time", evt_time, ht);
        end
    endtask

    task automatic wait_valid(input int n);
        for (int i = 0; i < n && !evt_valid; i++) tick();
        chk("wait_valid", 32'(evt_valid), 32'd1);
    endtask

    task automatic chk_bus(input string tag, input logic cs,
                           input logic wn, input logic [1:0] a,
                           input logic [31:0] d);
        chk({tag, "_cs"}, 32'(avm_chipselect), 32'(cs));
        chk({tag, "_wn"}, 32'(avm_write_n), 32'(wn));
        chk({tag, "_addr"}, 32'(avm_address), 32'(a));
        chk({tag, "_wdata"}, avm_writedata, d);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_bus(tag, 1'b0, 1'b1, 2'd0, 32'h0);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
        chk({tag, "_bits"}, evt_bits, 32'h0);
        chk({tag, "_time"}, evt_time, 32'h0);
        chk({tag, "_spur"}, 32'(spurious_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c_t;
        logic [31:0] t1;
        logic [31:0] m;
        reset_n   = 1'b0;
        evt_ready = 1'b0;
        pins      = '1;
        force_irq = 1'b0;
        #1;
        chk_reset_vals("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_bus("init", 1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF);
        tick();
        chk_bus("idle", 1'b0, 1'b1, 2'd0, 32'h0);
        repeat (3) tick();
        chk("mask_writes", 32'(s_mask_wr), 32'd1);
        chk("mask_value", s_mask, 32'hFFFF_FFFF);

        // Single edge on bit 5, consumer always ready.
        evt_ready = 1'b1;
        pins[5] = 1'b0;
        tick();
        c_t = cyc;
        chk("t_irq", 32'(irq), 32'd1);
        chk("t_valid0", 32'(evt_valid), 32'd0);
        tick();
        chk_bus("read", 1'b1, 1'b1, 2'd3, 32'h0);
        tick();
        pins = '1;
        chk_bus("clear", 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
        tick();
        chk("t3_valid", 32'(evt_valid), 32'd1);
        chk("t3_bits", evt_bits, 32'h20);
        chk("t3_time", evt_time, TS0 + c_t + 32'd2);
        chk("t3_wrapped", 32'(evt_time < TS0), 32'd1);
        tick();
        chk("t4_valid", 32'(evt_valid), 32'd0);
        chk("t4_irq", 32'(irq), 32'd0);

        // Back-pressure: second edge must wait for the first event.
        evt_ready = 1'b0;
        pins[0] = 1'b0;
        tick();
        pins = '1;
        wait_valid(10);
        chk("bp_bits1", evt_bits, 32'h1);
        pins[1] = 1'b0;
        tick();
        pins = '1;
        repeat (19) tick();
        chk("bp_hold_valid", 32'(evt_valid), 32'd1);
        chk("bp_hold_bits", evt_bits, 32'h1);
        chk("bp_no_read", 32'(avm_chipselect), 32'd0);
        t1 = evt_time;
        evt_ready = 1'b1;
        tick();
        wait_valid(10);
        chk("bp_bits2", evt_bits, 32'h2);
        chk("bp_later", 32'(evt_time > t1), 32'd1);
        tick();

        // Spurious interrupt with empty capture register.
        repeat (2) tick();
        force_irq = 1'b1;
        tick();
        force_irq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("spur_novalid", 32'(evt_valid), 32'd0);
        end
        chk("spur_one", 32'(spurious_cnt), 32'd1);
        chk("spur_model", 32'(spurious_cnt), 32'(exp_spur));

        // Random edges, forced irqs and consumer stalls.
        for (int k = 0; k < 80; k++) begin
            pins      = '1;
            force_irq = 1'b0;
            evt_ready = ($urandom_range(0, 3) != 0);
            if (!avm_chipselect && $urandom_range(0, 1) == 1) begin
                m = $urandom;
                m = m & $urandom;
                pins = ~m;
            end
            if (!avm_chipselect && $urandom_range(0, 7) == 0)
                force_irq = 1'b1;
            tick();
        end
        pins      = '1;
        force_irq = 1'b0;
        evt_ready = 1'b1;
        repeat (20) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_spur", 32'(spurious_cnt), 32'(exp_spur));
        chk("drain_idle", 32'(evt_valid), 32'd0);

        // Reset while an event is pending in PUSH.
        evt_ready = 1'b0;
        pins[3] = 1'b0;
        tick();
        pins = '1;
        wait_valid(10);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        hold = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_bus("reinit", 1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF);
        tick();
        chk_bus("reidle", 1'b0, 1'b1, 2'd0, 32'h0);
        chk("remask_writes", 32'(s_mask_wr), 32'd1);
        chk("re_novalid", 32'(evt_valid), 32'd0);
        evt_ready = 1'b1;
        pins[7] = 1'b0;
        tick();
        pins = '1;
        wait_valid(10);
        chk("re_bits", evt_bits, 32'h80);
        tick();
        repeat (3) tick();
        chk("re_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
